game_recharge: RTL and testbench

//   Top-up terminal for the game console credit counter: collects coin inserts,

---
 rtl/game_recharge.sv | 122 ++++++++++++
 tb/tb_game_recharge.sv | 134 +++++++++++++
 2 files changed

// File: rtl/game_recharge.sv
// game_recharge: coin top-up terminal that collects credit and loads it into the credit counter
// Refunds on cancel, inactivity timeout or counter-overflow excess.
module game_recharge #(
  parameter int MAX_CREDIT = 500,
  parameter int TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid_i,
  input  logic [1:0] coin_type_i,
  input  logic       confirm_i,
  input  logic       cancel_i,
  input  logic [9:0] remain_i,
  output logic [9:0] money_o,
  output logic       set_o,
  output logic [9:0] refund_o,
  output logic       refund_valid_o,
  output logic       coin_reject_o,
  output logic [9:0] credit_o,
  output logic       busy_o
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, REFUND} state_t;
  state_t          state_q, state_d;
  logic [9:0]      credit_q, credit_d, money_q, money_d, refund_q, refund_d;
  logic            set_q, set_d, rv_q, rv_d, rej_q, rej_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      value, room, excess;
  logic [10:0]     sum;
  logic            fits, take;
  always_comb begin
    value  = coin_type_i == 2'b00 ? 10'd1 : coin_type_i == 2'b01 ? 10'd5 :
             coin_type_i == 2'b10 ? 10'd10 : 10'd20;
    sum    = {1'b0, credit_q} + {1'b0, value};
    fits   = sum <= 11'(MAX_CREDIT);
    room   = 10'd1023 - remain_i;
    excess = credit_q - money_q;
  end
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    cnt_d    = '0;
    money_d  = '0;
    set_d    = 1'b0;
    refund_d = '0;
    rv_d     = 1'b0;
    take     = 1'b0;
    case (state_q)
      IDLE: begin
        take = coin_valid_i && fits;
        if (take) begin
          credit_d = sum[9:0];
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel_i) begin
          state_d  = REFUND;
          refund_d = credit_q;
          rv_d     = 1'b1;
        end else if (confirm_i) begin
          // money is fixed here from the remain sampled at the confirm edge
          state_d = COMMIT;
          money_d = credit_q < room ? credit_q : room;
          set_d   = 1'b1;
        end else if (coin_valid_i && fits) begin
          take     = 1'b1;
          credit_d = sum[9:0];
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = REFUND;
          refund_d = credit_q;
          rv_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        if (excess != 10'd0) begin
          state_d  = REFUND;
          refund_d = excess;
          rv_d     = 1'b1;
        end else begin
          state_d  = IDLE;
          credit_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
    rej_d = coin_valid_i && !take;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      cnt_q    <= '0;
      money_q  <= '0;
      set_q    <= 1'b0;
      refund_q <= '0;
      rv_q     <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      money_q  <= money_d;
      set_q    <= set_d;
      refund_q <= refund_d;
      rv_q     <= rv_d;
      rej_q    <= rej_d;
    end
  end
  assign money_o        = money_q;
  assign set_o          = set_q;
  assign refund_o       = refund_q;
  assign refund_valid_o = rv_q;
  assign coin_reject_o  = rej_q;
  assign credit_o       = credit_q;
  assign busy_o         = state_q != IDLE;
endmodule

// File: tb/tb_game_recharge.sv
// tb_game_recharge: randomized and directed stimulus against a session-level reference model
module tb_game_recharge;
  localparam int MAXC = 500;
  localparam int TO   = 8;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       coin_valid = 1'b0, confirm = 1'b0, cancel = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic [9:0] remain = '0;
  logic [9:0] money, refund, credit;
  logic       set, refund_valid, coin_reject, busy;
  game_recharge #(.MAX_CREDIT(MAXC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid_i(coin_valid), .coin_type_i(coin_type),
    .confirm_i(confirm), .cancel_i(cancel), .remain_i(remain), .money_o(money),
    .set_o(set), .refund_o(refund), .refund_valid_o(refund_valid),
    .coin_reject_o(coin_reject), .credit_o(credit), .busy_o(busy)
  );
  always #5 clk = ~clk;
  typedef struct {int id; int credit; int busy;} disp_t;
  typedef struct {int id; int rej; int set; int money; int rv; int refund;} ev_t;
  disp_t disp_q[$];
  ev_t   ev_q[$];
  int n_chk = 0, n_pass = 0, step_id = 0;
  bit run = 1'b0;
  // reference: a session is a pending amount plus where it is in its life cycle
  int pend = 0, phase = 0, idle = 0, excess = 0;
  task automatic chk(string name, logic [10:0] act, logic [10:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask
  function automatic int coin_value(logic [1:0] t);
    return t == 2'd0 ? 1 : t == 2'd1 ? 5 : t == 2'd2 ? 10 : 20;
  endfunction
  task automatic step(bit cv, logic [1:0] ct, bit cf, bit cn, int rem);
    ev_t e;
    int v;
    @(negedge clk);
    coin_valid = cv; coin_type = ct; confirm = cf; cancel = cn; remain = 10'(rem);
    v = coin_value(ct);
    e = '{step_id, 0, 0, 0, 0, 0};
    if (phase == 0) begin
      if (cv && pend + v <= MAXC) begin pend += v; phase = 1; idle = 0; end
      else e.rej = cv;
    end else if (phase == 1) begin
      if (cn) begin e.rv = 1; e.refund = pend; phase = 3; e.rej = cv; end
      else if (cf) begin
        e.set = 1; e.money = pend < 1023 - rem ? pend : 1023 - rem;
        excess = pend - e.money; phase = 2; e.rej = cv;
      end else if (cv && pend + v <= MAXC) begin pend += v; idle = 0; end
      else begin
        e.rej = cv;
        if (idle == TO - 1) begin e.rv = 1; e.refund = pend; phase = 3; end
        else idle++;
      end
    end else if (phase == 2) begin
      e.rej = cv;
      if (excess > 0) begin e.rv = 1; e.refund = excess; phase = 3; end
      else begin pend = 0; phase = 0; end
    end else begin
      e.rej = cv; pend = 0; phase = 0;
    end
    disp_q.push_back('{step_id, pend, phase != 0});
    if (e.rej || e.set || e.rv) ev_q.push_back(e);
    step_id++;
  endtask
  task automatic quiet(int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, 0, 0, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    run = 1'b0;
    coin_valid = 0; confirm = 0; cancel = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_money", money, 0); chk("rst_set", set, 0);
    chk("rst_refund", refund, 0); chk("rst_rv", refund_valid, 0);
    chk("rst_reject", coin_reject, 0); chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    disp_q.delete(); ev_q.delete();
    pend = 0; phase = 0; idle = 0; excess = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;
  endtask
  always @(posedge clk) begin
    disp_t d;
    ev_t e;
    #1;
    if (run && rst_n && disp_q.size() > 0) begin
      d = disp_q.pop_front();
      e = '{d.id, 0, 0, 0, 0, 0};
      if (ev_q.size() > 0 && ev_q[0].id == d.id) e = ev_q.pop_front();
      chk("credit", credit, 11'(d.credit));
      chk("busy", busy, 11'(d.busy));
      chk("coin_reject", coin_reject, 11'(e.rej));
      chk("set", set, 11'(e.set));
      chk("money", money, 11'(e.money));
      chk("refund_valid", refund_valid, 11'(e.rv));
      chk("refund", refund, 11'(e.refund));
      chk("set_rv_exclusive", set & refund_valid, 0);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    step(1, 2'd2, 0, 0, 0); step(1, 2'd1, 0, 0, 0);
    do_reset();
    step(1, 2'd2, 0, 0, 0); step(1, 2'd1, 0, 0, 0); step(1, 2'd0, 0, 0, 0);
    step(0, 2'd0, 1, 0, 100); quiet(3);
    for (int i = 0; i < 24; i++) step(1, 2'd3, 0, 0, 0);
    step(1, 2'd2, 0, 0, 0); step(1, 2'd3, 0, 0, 0); step(1, 2'd2, 0, 0, 0);
    step(1, 2'd0, 0, 0, 0); step(0, 2'd0, 0, 1, 0); quiet(3);
    step(1, 2'd3, 0, 0, 0); step(1, 2'd2, 0, 0, 0);
    step(0, 2'd0, 1, 0, 1000); step(1, 2'd0, 0, 0, 0); quiet(3);
    step(1, 2'd3, 0, 0, 0); step(1, 2'd1, 1, 1, 500); quiet(3);
    step(1, 2'd1, 0, 0, 0); quiet(12);
    step(1, 2'd3, 0, 0, 0); step(0, 2'd0, 1, 0, 1023); quiet(3);
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(99);
      int rem = $urandom_range(3) == 0 ? $urandom_range(1023, 990) : $urandom_range(1023);
      step($urandom_range(99) < 45, 2'($urandom_range(3)), r < 6, r >= 96, rem);
      if (i == 1500) do_reset();
    end
    quiet(2);
    @(negedge clk); @(negedge clk);
    chk("queues_drained", 11'(disp_q.size() + ev_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
